bin_to_bcd_lednum: RTL and testbench

Sequential binary-to-packed-BCD converter that produces the 16-bit lednum word consumed directly by Led_Display. It takes an unsigned binary count (0..9999) and converts it with a shift-and-add-3 (double-dabble) iteration, one bit per clock. lednum is a registered holding value: it stays stable during conversion and changes only on completion, so the display never shows partial results.

---
 rtl/bcd_pkg.sv | 15 +
 rtl/bcd_add3_digit.sv | 10 +
 rtl/bin_to_bcd_lednum.sv | 118 +++++++++++
 tb/tb_bin_to_bcd_lednum.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-lednum BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        FINISH
    } state_t;

    localparam int              DIGITS   = 4;
    localparam int              MAX_VAL  = 9999;
    localparam int              LEDNUM_W = 16;
    localparam logic [15:0]     OVF_SAT  = 16'h9999;

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3_digit (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/bin_to_bcd_lednum.sv
// Sequential double-dabble converter producing the packed-BCD lednum word;
// lednum only changes on completion so the display never shows partial data.
module bin_to_bcd_lednum
    import bcd_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BIN_W-1:0]    bin_in,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [LEDNUM_W-1:0] lednum
);

    localparam int                   CNT_W    = $clog2(BIN_W);
    localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(BIN_W - 1);
    localparam logic [BIN_W-1:0]     MAX_IN   = BIN_W'(MAX_VAL);

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [BIN_W-1:0]            r_shift;
    logic [LEDNUM_W-1:0]         r_bcd;
    logic [CNT_W-1:0]            r_cnt;
    logic [LEDNUM_W-1:0]         r_lednum;
    logic                        r_busy;
    logic                        r_done;
    logic                        r_overflow;

    logic                        w_accept;
    logic                        w_in_range;
    logic [LEDNUM_W-1:0]         w_bcd_adj;
    logic [LEDNUM_W+BIN_W-1:0]   w_shifted;

    assign w_accept   = start && (r_state == IDLE);
    assign w_in_range = (bin_in <= MAX_IN);

    // Correct every digit first, then shift the combined {bcd, shift} word.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_add3_digit u_add3 (
            .i_digit (r_bcd[4*g +: 4]),
            .o_digit (w_bcd_adj[4*g +: 4])
        );
    end

    assign w_shifted = {w_bcd_adj, r_shift} << 1;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start && w_in_range) w_state_nxt = CONV;
            CONV:    if (r_cnt == LAST_CNT)   w_state_nxt = FINISH;
            FINISH:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift    <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_lednum   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept && w_in_range) begin
                        r_shift    <= bin_in;
                        r_bcd      <= '0;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_overflow <= 1'b0;
                    end else if (w_accept) begin
                        // Out-of-range input saturates immediately without iterating.
                        r_lednum   <= OVF_SAT;
                        r_overflow <= 1'b1;
                        r_done     <= 1'b1;
                    end
                end
                CONV: begin
                    r_bcd   <= w_shifted[LEDNUM_W+BIN_W-1:BIN_W];
                    r_shift <= w_shifted[BIN_W-1:0];
                    r_cnt   <= r_cnt + 1'b1;
                end
                FINISH: begin
                    r_lednum <= r_bcd;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign overflow = r_overflow;
    assign lednum   = r_lednum;

endmodule

// File: tb/tb_bin_to_bcd_lednum.sv
// Scoreboard bench: the driver predicts each conversion from decimal arithmetic,
// and a negedge monitor compares done/busy/lednum/overflow every cycle.
module tb_bin_to_bcd_lednum;

    localparam int BIN_W = 14;
    localparam int LAT   = BIN_W + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [BIN_W-1:0] bin_in;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [15:0]      lednum;

    bin_to_bcd_lednum #(.BIN_W(BIN_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bin_in   (bin_in),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .lednum   (lednum)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [15:0] led;
        logic        ovf;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] m_led    = 16'h0000;
    logic        m_ovf    = 1'b0;
    int          idle_from = 0;
    int          busy_from = 1;
    int          busy_to   = 0;
    bit          mon_en    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_lednum(input int v);
        if (v > 9999) return 16'h9999;
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // All driver tasks start and end at posedge+1 time units.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input int v);
        int e;
        bit acc;
        bit ov;
        start  = 1'b1;
        bin_in = BIN_W'(v);
        e      = cyc + 1;
        acc    = (e >= idle_from);
        ov     = (v > 9999);
        if (acc) begin
            if (ov) begin
                q.push_back('{e, 16'h9999, 1'b1});
                idle_from = e + 1;
            end else begin
                q.push_back('{e + LAT, ref_lednum(v), 1'b0});
                busy_from = e;
                busy_to   = e + LAT - 1;
                idle_from = e + LAT + 1;
            end
        end
        step(1);
        start = 1'b0;
        if (acc) m_ovf = ov;
    endtask

    task automatic wait_ready();
        while (cyc + 1 < idle_from) step(1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        q.delete();
        m_led     = 16'h0000;
        m_ovf     = 1'b0;
        busy_from = 1;
        busy_to   = 0;
        idle_from = cyc + 1;
    endtask

    always @(negedge clk) begin
        logic due_now;
        if (mon_en) begin
            due_now = (q.size() > 0) && (q[0].due == cyc);
            check("done", done, due_now);
            check("busy", busy, (cyc >= busy_from) && (cyc <= busy_to));
            if (due_now) begin
                check("lednum_update", lednum, q[0].led);
                check("overflow_update", overflow, q[0].ovf);
                m_led = q[0].led;
                void'(q.pop_front());
            end else begin
                check("lednum_hold", lednum, m_led);
                check("overflow_hold", overflow, m_ovf);
            end
        end
    end

    initial begin
        int v;
        rst    = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        idle_from = cyc + 1;
        mon_en    = 1'b1;
        step(2);

        issue(1234);
        wait_ready();
        issue(0);
        wait_ready();
        issue(9999);
        wait_ready();
        issue(7);
        wait_ready();

        issue(10000);
        issue(42);
        wait_ready();

        issue(5678);
        step(3);
        issue(1111);
        for (int i = 0; i < 6; i++) begin
            bin_in = BIN_W'($urandom_range(0, 16383));
            step(1);
        end
        wait_ready();

        issue(3000);
        wait_ready();
        issue(25);
        wait_ready();

        issue(8888);
        step(6);
        do_reset();
        step(3);
        issue(8888);
        wait_ready();

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) v = $urandom_range(10000, 16383);
            else                           v = $urandom_range(0, 9999);
            if ($urandom_range(0, 2) == 0) wait_ready();
            else                           step($urandom_range(0, 20));
            issue(v);
            if ($urandom_range(0, 3) == 0) issue($urandom_range(0, 9999));
            bin_in = BIN_W'($urandom_range(0, 16383));
        end

        for (int i = 0; i < 200 && q.size() > 0; i++) step(1);
        check("scoreboard_drain", q.size(), 0);
        step(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
